// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bundles the register file's read ports, both write ports
// and the clear handshake. The master side drives addresses, write requests
// and clr_req; the slave side (the register file) returns read data and busy.
interface reg_file_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rdata;
  logic                wen0;
  logic [AW-1:0]       waddr0;
  logic [XLEN-1:0]     wdata0;
  logic                wen1;
  logic [AW-1:0]       waddr1;
  logic [XLEN-1:0]     wdata1;
  logic                clr_req;
  logic                busy;

  modport master (
    output rs_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, clr_req,
    input  rdata, busy
  );

  modport slave (
    input  rs_addr, wen0, waddr0, wdata0, wen1, waddr1, wdata1, clr_req,
    output rdata, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with two write ports
// (port 1 wins on collision), optional same-cycle write-to-read bypass and a
// sequential clear engine that zeroes one register per cycle after reset or
// on clr_req. Register 0 always reads as zero; out-of-range addresses are
// ignored on writes and read as zero.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_EXT = (AW + 1)'(NREGS);

  logic [0:0]      state;
  logic [AW-1:0]   clr_cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr0_ok;
  logic            wr1_ok;

  // The extra leading zero keeps the compare meaningful when NREGS is a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS_EXT;
  endfunction

  // Qualify each write port; port 0 yields to port 1 when both hit the same register.
  always_comb begin
    wr1_ok = bus.wen1 && (bus.waddr1 != '0) && in_range(bus.waddr1);
    wr0_ok = bus.wen0 && (bus.waddr0 != '0) && in_range(bus.waddr0)
             && !(wr1_ok && (bus.waddr1 == bus.waddr0));
  end

  // Clear sequencer: walk clr_cnt over every register, restarting on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state   <= S_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + AW'(1);
      end
    end else if (bus.clr_req) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end
  end

  // Array update: zero one entry per cycle while clearing, otherwise accept writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        regs[clr_cnt] <= '0;
      end else begin
        if (wr0_ok) regs[bus.waddr0] <= bus.wdata0;
        if (wr1_ok) regs[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  assign bus.busy = (state == S_CLEAR);

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;

    assign a = bus.rs_addr[g*AW +: AW];

    // Combinational read with zero masking and optional forwarding of this cycle's writes.
    always_comb begin
      v = '0;
      if ((state == S_CLEAR) || (a == '0) || !in_range(a)) begin
        v = '0;
      end else if ((BYPASS != 0) && bus.wen1 && (bus.waddr1 == a)) begin
        v = bus.wdata1;
      end else if ((BYPASS != 0) && bus.wen0 && (bus.waddr0 == a)) begin
        v = bus.wdata0;
      end else begin
        v = regs[a];
      end
    end

    assign bus.rdata[g*XLEN +: XLEN] = v;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: drives one stimulus stream into three register files
// (32 regs with bypass, 32 regs without bypass, 24 regs with three read
// ports) and compares every output with a behavioural model.
module tb_reg_file_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs [3];
  logic        wen0, wen1, clr_req;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;

  int checks = 0;
  int failures = 0;

  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifA ();
  reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) ifB ();
  reg_file_mp_if #(.XLEN(32), .NREGS(24), .NRD(3)) ifC ();

  assign ifA.rs_addr = {rs[1], rs[0]};
  assign ifA.wen0 = wen0;     assign ifA.waddr0 = waddr0; assign ifA.wdata0 = wdata0;
  assign ifA.wen1 = wen1;     assign ifA.waddr1 = waddr1; assign ifA.wdata1 = wdata1;
  assign ifA.clr_req = clr_req;
  assign ifB.rs_addr = {rs[1], rs[0]};
  assign ifB.wen0 = wen0;     assign ifB.waddr0 = waddr0; assign ifB.wdata0 = wdata0;
  assign ifB.wen1 = wen1;     assign ifB.waddr1 = waddr1; assign ifB.wdata1 = wdata1;
  assign ifB.clr_req = clr_req;
  assign ifC.rs_addr = {rs[2], rs[1], rs[0]};
  assign ifC.wen0 = wen0;     assign ifC.waddr0 = waddr0; assign ifC.wdata0 = wdata0;
  assign ifC.wen1 = wen1;     assign ifC.waddr1 = waddr1; assign ifC.wdata1 = wdata1;
  assign ifC.clr_req = clr_req;

  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dutA (.clk(clk), .rst(rst), .bus(ifA.slave));
  reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dutB (.clk(clk), .rst(rst), .bus(ifB.slave));
  reg_file_mp #(.XLEN(32), .NREGS(24), .NRD(3), .BYPASS(1)) dutC (.clk(clk), .rst(rst), .bus(ifC.slave));

  // Reference model: contents, busy flag and remaining clear cycles per instance.
  int          m_nregs [3] = '{32, 32, 24};
  bit          m_byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_mem   [3][64];
  bit          m_busy  [3];
  int          m_rem   [3];

  function automatic logic [31:0] expRead(int k, logic [4:0] a);
    if (m_busy[k] || a == 5'd0 || int'(a) >= m_nregs[k]) return 32'd0;
    if (m_byp[k] && wen1 && waddr1 == a) return wdata1;
    if (m_byp[k] && wen0 && waddr0 == a) return wdata0;
    return m_mem[k][a];
  endfunction

  function automatic void modelTick();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] = 1'b1;
        m_rem[k]  = m_nregs[k];
      end else if (m_busy[k]) begin
        m_rem[k]--;
        if (m_rem[k] == 0) begin
          m_busy[k] = 1'b0;
          for (int r = 0; r < 64; r++) m_mem[k][r] = 32'd0;
        end
      end else begin
        if (wen0 && waddr0 != 5'd0 && int'(waddr0) < m_nregs[k]) m_mem[k][waddr0] = wdata0;
        if (wen1 && waddr1 != 5'd0 && int'(waddr1) < m_nregs[k]) m_mem[k][waddr1] = wdata1;
        if (clr_req) begin
          m_busy[k] = 1'b1;
          m_rem[k]  = m_nregs[k];
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                               input logic clr);
    wen0 = w0; waddr0 = a0; wdata0 = d0;
    wen1 = w1; waddr1 = a1; wdata1 = d1;
    rs[0] = r0; rs[1] = r1; rs[2] = r2;
    clr_req = clr;
  endtask

  task automatic applyRandom(input logic clr);
    applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), clr);
  endtask

  task automatic checkOutput();
    #1;
    chk("A.busy", 32'(ifA.busy), 32'(m_busy[0]));
    chk("B.busy", 32'(ifB.busy), 32'(m_busy[1]));
    chk("C.busy", 32'(ifC.busy), 32'(m_busy[2]));
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("A.rd%0d@%0d", p, rs[p]), ifA.rdata[p*32 +: 32], expRead(0, rs[p]));
      chk($sformatf("B.rd%0d@%0d", p, rs[p]), ifB.rdata[p*32 +: 32], expRead(1, rs[p]));
    end
    for (int p = 0; p < 3; p++)
      chk($sformatf("C.rd%0d@%0d", p, rs[p]), ifC.rdata[p*32 +: 32], expRead(2, rs[p]));
  endtask

  task automatic tick();
    @(posedge clk);
    modelTick();
    @(negedge clk);
  endtask

  // Counts cycles with A busy while random writes are attempted; optional extra clr_req.
  task automatic countBusy(input string tag, input int clr_at);
    int cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (ifA.busy !== 1'b1) break;
      applyRandom(1'(i == clr_at));
      checkOutput();
      cnt++;
      tick();
    end
    chk(tag, 32'(cnt), 32'd32);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b1;
      m_rem[k]  = m_nregs[k];
      for (int r = 0; r < 64; r++) m_mem[k][r] = 32'd0;
    end
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    checkOutput();
    tick();
    tick();
    rst = 1'b0;
    countBusy("reset_clear_len", -1);

    // Garbage, then a 3-cycle reset with writes attempted, then clear timing.
    for (int i = 0; i < 6; i++) begin
      applyRandom(1'b0);
      checkOutput();
      tick();
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyRandom(1'b0);
      tick();
    end
    rst = 1'b0;
    countBusy("rst_clear_len", -1);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i), 0);
      checkOutput();
      chk("cleared_zero", ifA.rdata[31:0], 32'd0);
    end

    // Dual-write collision, then split addresses.
    applyStimulus(1, 5, 32'h1111_1111, 1, 5, 32'h2222_2222, 5, 0, 5, 0);
    checkOutput();
    tick();
    applyStimulus(1, 6, 32'h6666_6666, 1, 7, 32'h7777_7777, 5, 6, 7, 0);
    checkOutput();
    chk("collision_p1_wins", ifB.rdata[31:0], 32'h2222_2222);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 7, 5, 0);
    checkOutput();
    chk("split_w0", ifB.rdata[31:0], 32'h6666_6666);
    chk("split_w1", ifB.rdata[63:32], 32'h7777_7777);

    // Bypass: A forwards, B shows the old value until the next cycle.
    applyStimulus(1, 9, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    tick();
    applyStimulus(1, 9, 32'hDEAD_BEEF, 0, 0, 0, 0, 9, 9, 0);
    checkOutput();
    chk("bypass_on", ifA.rdata[63:32], 32'hDEAD_BEEF);
    chk("bypass_off_old", ifB.rdata[63:32], 32'h0000_1234);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 9, 0);
    checkOutput();
    chk("bypass_off_new", ifB.rdata[63:32], 32'hDEAD_BEEF);

    // Writes to register 0 never show up.
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checkOutput();
    chk("x0_same_A", ifA.rdata[31:0], 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput();
    chk("x0_next_B", ifB.rdata[63:32], 32'd0);

    // Out-of-range address for the 24-entry instance.
    applyStimulus(1, 30, 32'hCAFE_0030, 0, 0, 0, 30, 30, 30, 0);
    checkOutput();
    chk("oor_same_C", ifC.rdata[95:64], 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 30, 30, 30, 0);
    checkOutput();
    chk("oor_next_C", ifC.rdata[31:0], 32'd0);
    chk("addr30_A", ifA.rdata[31:0], 32'hCAFE_0030);

    // Random traffic with occasional clear requests.
    for (int i = 0; i < 300; i++) begin
      applyRandom(1'($urandom_range(0, 59) == 0));
      checkOutput();
      tick();
    end
    for (int i = 0; i < 100 && ifA.busy; i++) begin
      applyRandom(1'b0);
      tick();
    end

    // clr_req with a same-cycle write, then a second clr_req mid-clear.
    applyStimulus(1, 3, 32'h0000_00A5, 0, 0, 0, 3, 3, 3, 1);
    checkOutput();
    tick();
    chk("clr_busy_next", 32'(ifA.busy), 32'd1);
    countBusy("clr_len_with_second_req", 10);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 3, 3, 0);
    checkOutput();
    chk("reg3_cleared", ifA.rdata[31:0], 32'd0);

    // Reset during a clear restarts the full sequence.
    applyStimulus(1, 4, 32'h0000_0044, 0, 0, 0, 4, 4, 4, 1);
    checkOutput();
    tick();
    for (int i = 0; i < 10; i++) begin
      applyRandom(1'b0);
      checkOutput();
      tick();
    end
    rst = 1'b1;
    applyRandom(1'b0);
    tick();
    rst = 1'b0;
    countBusy("rst_mid_clear_len", -1);
    for (int i = 0; i < 40; i++) begin
      applyRandom(1'b0);
      checkOutput();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
